// File: rtl/spi_master_ctrl.sv
// SPI transaction sequencer (mode 0): accepts a word, frames it with chip select,
// divides the system clock into SCLK and drives load/enable to the transmit shifter.
module spi_master_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             CS_n_o,
    output logic             SCLK_o,
    output logic             tx_load_o,
    output logic             tx_en_o,
    output logic [WIDTH-1:0] tx_data_o
);

    localparam int PW   = $clog2(CLK_DIV + 1);
    localparam int EW   = $clog2(WIDTH + 1);
    localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [EW-1:0] edge_cnt, edge_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic          abort_flag, abort_flag_nxt;
    logic          sclk_nxt;
    logic          ready_nxt, done_nxt, aborted_nxt, cs_n_nxt, load_nxt, en_nxt;
    logic          accept;

    assign accept = (state == IDLE) && start_i;

    // State, counters, abort latch and captured word
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            phase      <= '0;
            edge_cnt   <= '0;
            cyc        <= '0;
            abort_flag <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            edge_cnt   <= edge_nxt;
            cyc        <= cyc_nxt;
            abort_flag <= abort_flag_nxt;
            if (accept) begin
                tx_data_o <= data_i;
            end else begin
                tx_data_o <= tx_data_o;
            end
        end
    end

    // Next-state, counter and SCLK sequencing; abort overrides the normal exit
    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        edge_nxt       = edge_cnt;
        cyc_nxt        = cyc;
        abort_flag_nxt = abort_flag;
        sclk_nxt       = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                edge_nxt  = '0;
                cyc_nxt   = '0;
                if (start_i) begin
                    state_nxt      = LOAD;
                    abort_flag_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                cyc_nxt = '0;
                if (abort_i) begin
                    state_nxt      = HOLD;
                    abort_flag_nxt = 1'b1;
                end else begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (abort_i) begin
                    state_nxt      = HOLD;
                    abort_flag_nxt = 1'b1;
                    cyc_nxt        = '0;
                end else if (cyc == CW'(CS_SETUP - 1)) begin
                    state_nxt = XFER;
                    cyc_nxt   = '0;
                    phase_nxt = '0;
                    edge_nxt  = '0;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            XFER: begin
                sclk_nxt = SCLK_o;
                if (abort_i) begin
                    state_nxt      = HOLD;
                    abort_flag_nxt = 1'b1;
                    phase_nxt      = '0;
                    edge_nxt       = '0;
                    cyc_nxt        = '0;
                    sclk_nxt       = 1'b0;
                end else if (phase == PW'(CLK_DIV - 1)) begin
                    phase_nxt = '0;
                    sclk_nxt  = ~SCLK_o;
                    // A wrap while SCLK is high is a falling toggle
                    if (SCLK_o && (edge_cnt == EW'(WIDTH - 1))) begin
                        state_nxt = HOLD;
                        edge_nxt  = '0;
                        cyc_nxt   = '0;
                    end else if (SCLK_o) begin
                        edge_nxt = edge_cnt + EW'(1);
                    end else begin
                        edge_nxt = edge_cnt;
                    end
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            HOLD: begin
                if (cyc == CW'(CS_HOLD - 1)) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                edge_nxt  = '0;
                cyc_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        ready_nxt   = 1'b0;
        cs_n_nxt    = 1'b1;
        load_nxt    = 1'b0;
        en_nxt      = 1'b0;
        case (state_nxt)
            IDLE: begin
                ready_nxt = 1'b1;
            end
            LOAD: begin
                load_nxt = 1'b1;
            end
            SETUP, XFER, HOLD: begin
                cs_n_nxt = 1'b0;
                en_nxt   = 1'b1;
            end
            default: begin
                ready_nxt = 1'b1;
            end
        endcase
        if ((state == HOLD) && (state_nxt == IDLE)) begin
            done_nxt = 1'b1;
        end else begin
            done_nxt = 1'b0;
        end
        aborted_nxt = done_nxt & abort_flag;
    end

    // Output registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
            CS_n_o    <= 1'b1;
            SCLK_o    <= 1'b0;
            tx_load_o <= 1'b0;
            tx_en_o   <= 1'b0;
        end else begin
            ready_o   <= ready_nxt;
            busy_o    <= ~ready_nxt;
            done_o    <= done_nxt;
            aborted_o <= aborted_nxt;
            CS_n_o    <= cs_n_nxt;
            SCLK_o    <= sclk_nxt;
            tx_load_o <= load_nxt;
            tx_en_o   <= en_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default timing and the fastest timing)
// driven by directed and random start/abort traffic against a transfer-timeline model.
module tb_spi_master_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_v [2];
    logic         abort_v [2];
    logic [W-1:0] data_v  [2];
    logic         ready_v [2], busy_v [2], done_v [2], aborted_v [2];
    logic         csn_v   [2], sclk_v [2], load_v [2], en_v [2];
    logic [W-1:0] txd_v   [2];

    spi_master_ctrl dut (
        .clock_i(clk), .reset_i(rst), .start_i(start_v[0]), .abort_i(abort_v[0]),
        .data_i(data_v[0]), .ready_o(ready_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
        .aborted_o(aborted_v[0]), .CS_n_o(csn_v[0]), .SCLK_o(sclk_v[0]),
        .tx_load_o(load_v[0]), .tx_en_o(en_v[0]), .tx_data_o(txd_v[0])
    );

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_fast (
        .clock_i(clk), .reset_i(rst), .start_i(start_v[1]), .abort_i(abort_v[1]),
        .data_i(data_v[1]), .ready_o(ready_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
        .aborted_o(aborted_v[1]), .CS_n_o(csn_v[1]), .SCLK_o(sclk_v[1]),
        .tx_load_o(load_v[1]), .tx_en_o(en_v[1]), .tx_data_o(txd_v[1])
    );

    // Per-instance timing parameters
    int p_s [2] = '{2, 1};
    int p_d [2] = '{4, 1};
    int p_h [2] = '{2, 1};

    // Model: n counts clock edges since the accepting edge
    bit           m_busy [2];
    int           m_n    [2];
    bit           m_ab   [2];
    int           m_a    [2];
    bit           m_done [2];
    logic [W-1:0] m_txd  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dones  [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int x_end(input int i);
        return m_ab[i] ? m_a[i] : (p_s[i] + 2 * W * p_d[i] + 1);
    endfunction

    // {ready, busy, done, aborted, cs_n, sclk, load, en}
    function automatic logic [7:0] exp_outs(input int i);
        int  n;
        logic sc;
        n = m_n[i];
        if (!m_busy[i]) return {1'b1, 1'b0, m_done[i], m_done[i] & m_ab[i], 4'b1000};
        if (n == 0) return 8'b0100_1010;
        if (n < x_end(i)) begin
            sc = (n > p_s[i]) ? 1'(((n - p_s[i] - 1) / p_d[i]) % 2) : 1'b0;
            return {6'b010000, 1'b0, 1'b1} | {2'b00, 1'b0, 1'b0, 1'b0, sc, 2'b00};
        end
        return 8'b0100_0001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_n[i] = 0; m_ab[i] = 1'b0; m_a[i] = 0;
            m_done[i] = 1'b0; m_txd[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input bit a, input logic [W-1:0] d);
        if (!m_busy[i]) begin
            m_done[i] = 1'b0;
            if (s) begin
                m_busy[i] = 1'b1; m_n[i] = 0; m_ab[i] = 1'b0; m_txd[i] = d;
            end
        end else begin
            if (a && (m_n[i] < x_end(i))) begin
                m_ab[i] = 1'b1;
                m_a[i]  = m_n[i] + 1;
            end
            m_n[i]++;
            if (m_n[i] == x_end(i) + p_h[i]) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] obs;
        for (int i = 0; i < 2; i++) begin
            obs = {ready_v[i], busy_v[i], done_v[i], aborted_v[i],
                   csn_v[i], sclk_v[i], load_v[i], en_v[i]};
            check($sformatf("outs%0d@%0d", i, cyc), 32'(obs), 32'(exp_outs(i)));
            check($sformatf("txd%0d@%0d", i, cyc), 32'(txd_v[i]), 32'(m_txd[i]));
            if (done_v[i] === 1'b1) dones[i]++;
        end
    endtask

    task automatic tick(input bit s0, input bit a0, input logic [W-1:0] d0,
                        input bit s1, input bit a1, input logic [W-1:0] d1);
        @(negedge clk);
        check_all();
        start_v[0] = s0; abort_v[0] = a0; data_v[0] = d0;
        start_v[1] = s1; abort_v[1] = a1; data_v[1] = d1;
        model_step(0, s0, a0, d0);
        model_step(1, s1, a1, d1);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int d0_before;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; data_v[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Single A5 transfer on both instances
        tick(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5);
        idle(75);
        check("done_count_single", 32'(dones[0]), 32'd1);

        // start held continuously: back-to-back transfers
        for (int j = 0; j < 150; j++) tick(1'b1, 1'b0, 8'(j), 1'b1, 1'b0, 8'(j + 1));
        idle(75);

        // start mid-transfer with FF must be ignored
        d0_before = dones[0];
        tick(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
        idle(29);
        tick(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
        check("txd_hold_midxfer", 32'(txd_v[0]), 32'h0000_00A5);
        idle(50);
        check("one_done_ignored_start", 32'(dones[0] - d0_before), 32'd1);

        // abort after the third SCLK rising edge (n = 23 with defaults)
        tick(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C);
        idle(23);
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
        idle(10);

        // asynchronous reset between clock edges during XFER
        tick(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A);
        idle(30);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        tick(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hC3);
        idle(75);

        // Random traffic with occasional aborts
        for (int j = 0; j < 3000; j++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
        end
        idle(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
